sdram_write: RTL

- Write-side companion of the SDRAM read engine. It runs one burst write per request: ACTIVE, WRITE with data, BURST TERMINATE, then precharge, and signals completion.
- It sits between the SDRAM arbiter (which muxes its command, address and data onto the SDRAM pins) and an upstream first-word-fall-through write FIFO.
- It only operates after initialization has completed.

---
 rtl/sdram_write.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sdram_write.sv
// SDRAM burst write engine: ACTIVE, WRITE with data, BURST TERMINATE, optional
// PRECHARGE, then a one-cycle completion pulse. The upstream FIFO is
// first-word-fall-through and is popped by wr_ack. The arbiter muxes the
// command, address and data outputs onto the SDRAM pins.
module sdram_write #(
    parameter int TRCD_COUNT = 2,  // ACTIVE-to-WRITE dwell, must be >= 1
    parameter int TWR_COUNT  = 2,  // write recovery dwell, must be >= 1
    parameter int TRP_COUNT  = 2   // precharge dwell, must be >= 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        wr_en,
    input  logic [24:0] wr_addri,
    input  logic [7:0]  wr_blength,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        wr_end,
    output logic [3:0]  wr_cmdo,
    output logic [1:0]  wr_bao,
    output logic [11:0] wr_addro,
    output logic [15:0] wr_datao,
    output logic        wr_sdram_en
);

    // SDRAM commands as {CS#, RAS#, CAS#, WE#}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_BURST_TER = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ACTIVE     = 4'd1;
    localparam logic [3:0] S_WAIT_TRCD  = 4'd2;
    localparam logic [3:0] S_WRITE      = 4'd3;
    localparam logic [3:0] S_WRITE_DATA = 4'd4;
    localparam logic [3:0] S_BURST_TERM = 4'd5;
    localparam logic [3:0] S_WAIT_TWR   = 4'd6;
    localparam logic [3:0] S_PRECHARGE  = 4'd7;
    localparam logic [3:0] S_WAIT_TRP   = 4'd8;
    localparam logic [3:0] S_END        = 4'd9;

    // Last counter value of each timed dwell
    localparam logic [7:0] TRCD_LAST = 8'(TRCD_COUNT - 1);
    localparam logic [7:0] TWR_LAST  = 8'(TWR_COUNT - 1);
    localparam logic [7:0] TRP_LAST  = 8'(TRP_COUNT - 1);

    logic [3:0]  state;
    logic [3:0]  next_state;
    logic [7:0]  cnt;

    // Request fields captured at accept; the inputs are not looked at again
    logic [1:0]  bank_q;
    logic [11:0] row_q;
    logic        auto_pre_q;
    logic [7:0]  col_q;
    logic [7:0]  blen_q;
    logic [7:0]  burst_len;

    // A zero-length request still writes one word
    assign burst_len = (blen_q == 8'd0) ? 8'd1 : blen_q;

    // Next-state decode; every dwell ends on its counter's last value
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            S_IDLE:       if (wr_en && init_end) next_state = S_ACTIVE;
            S_ACTIVE:     next_state = S_WAIT_TRCD;
            S_WAIT_TRCD:  if (cnt == TRCD_LAST) next_state = S_WRITE;
            S_WRITE:      next_state = (burst_len <= 8'd1) ? S_BURST_TERM : S_WRITE_DATA;
            S_WRITE_DATA: if (cnt == burst_len - 8'd2) next_state = S_BURST_TERM;
            S_BURST_TERM: next_state = S_WAIT_TWR;
            S_WAIT_TWR:   if (cnt == TWR_LAST) next_state = auto_pre_q ? S_WAIT_TRP : S_PRECHARGE;
            S_PRECHARGE:  next_state = S_WAIT_TRP;
            S_WAIT_TRP:   if (cnt == TRP_LAST) next_state = S_END;
            S_END:        next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // State register, per-state cycle counter and request capture
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            // NOTE: non-blocking assignments for all clocked state, so every register sees pre-edge values.
            state      <= S_IDLE;
            cnt        <= 8'd0;
            bank_q     <= 2'd0;
            row_q      <= 12'd0;
            auto_pre_q <= 1'b0;
            col_q      <= 8'd0;
            blen_q     <= 8'd0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? 8'd0 : cnt + 8'd1;
            if (state == S_IDLE && wr_en && init_end) begin
                bank_q     <= wr_addri[24:23];
                row_q      <= wr_addri[22:11];
                auto_pre_q <= wr_addri[10];
                col_q      <= wr_addri[7:0];
                blen_q     <= wr_blength;
            end
        end
    end

    assign wr_ack = (state == S_WRITE) || (state == S_WRITE_DATA);
    assign wr_end = (state == S_END);

    // Command/address pins, registered from the current state
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_cmdo  <= CMD_NOP;
            wr_bao   <= 2'b11;
            wr_addro <= 12'hFFF;
        end else begin
            case (state)
                S_ACTIVE: begin
                    wr_cmdo  <= CMD_ACTIVE;
                    wr_bao   <= bank_q;
                    wr_addro <= row_q;
                end
                S_WRITE: begin
                    wr_cmdo  <= CMD_WRITE;
                    wr_bao   <= bank_q;
                    wr_addro <= {1'b0, auto_pre_q, 2'b00, col_q};
                end
                S_BURST_TERM: begin
                    wr_cmdo  <= CMD_BURST_TER;
                    wr_bao   <= 2'b11;
                    wr_addro <= 12'hFFF;
                end
                S_PRECHARGE: begin
                    // A10 low: precharge only the selected bank
                    wr_cmdo  <= CMD_PRECHARGE;
                    wr_bao   <= bank_q;
                    wr_addro <= 12'h000;
                end
                default: begin
                    wr_cmdo  <= CMD_NOP;
                    wr_bao   <= 2'b11;
                    wr_addro <= 12'hFFF;
                end
            endcase
        end
    end

    // DQ data and output enable, one cycle behind the FIFO pop so word 0 lines up with WRITE
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_datao    <= 16'd0;
            wr_sdram_en <= 1'b0;
        end else begin
            wr_sdram_en <= wr_ack;
            if (wr_ack) wr_datao <= wr_data;
        end
    end

endmodule
